// File: rtl/add_rs_if.sv
// Issue, CDB, adder-completion and dispatch bundle for the add/sub reservation station.
interface add_rs_if #(
   parameter int ENTRIES = 3,
   parameter int XLEN    = 32,
   parameter int TAGW    = 3
);
   localparam int CNTW = $clog2(ENTRIES + 1);

   logic            issue_valid;
   logic            issue_ready;
   logic [6:0]      issue_fun7;
   logic [XLEN-1:0] issue_val1;
   logic [XLEN-1:0] issue_val2;
   logic            issue_rdy1;
   logic            issue_rdy2;
   logic [TAGW-1:0] issue_tag1;
   logic [TAGW-1:0] issue_tag2;
   logic [TAGW-1:0] issue_des;
   logic            cdb_valid;
   logic [TAGW-1:0] cdb_tag;
   logic [XLEN-1:0] cdb_data;
   logic            adder_done;
   logic [XLEN-1:0] data1;
   logic [XLEN-1:0] data2;
   logic [TAGW-1:0] des;
   logic [6:0]      fun7;
   logic            fla;
   logic [CNTW-1:0] count;

   modport master (
      output issue_valid, issue_fun7, issue_val1, issue_val2, issue_rdy1, issue_rdy2,
             issue_tag1, issue_tag2, issue_des, cdb_valid, cdb_tag, cdb_data, adder_done,
      input  issue_ready, data1, data2, des, fun7, fla, count
   );

   modport slave (
      input  issue_valid, issue_fun7, issue_val1, issue_val2, issue_rdy1, issue_rdy2,
             issue_tag1, issue_tag2, issue_des, cdb_valid, cdb_tag, cdb_data, adder_done,
      output issue_ready, data1, data2, des, fun7, fla, count
   );
endinterface

// File: rtl/add_rs_station.sv
// Add/sub reservation station: holds issued ops, snoops the CDB, fires one ready op at a time.
// Optional macro RS_WAKE_BYPASS_EN lets a slot woken by the CDB dispatch in the same cycle.
module add_rs_station #(
   parameter int ENTRIES = 3,
   parameter int XLEN    = 32,
   parameter int TAGW    = 3
) (
   input logic    clk1,
   input logic    rst,
   add_rs_if.slave rs
);
   localparam int CNTW = $clog2(ENTRIES + 1);
   localparam int IDXW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [ENTRIES-1:0] r1_q, r1_d, r2_q, r2_d;
   logic [6:0]         fun7_q [ENTRIES];
   logic [6:0]         fun7_d [ENTRIES];
   logic [XLEN-1:0]    v1_q [ENTRIES];
   logic [XLEN-1:0]    v1_d [ENTRIES];
   logic [XLEN-1:0]    v2_q [ENTRIES];
   logic [XLEN-1:0]    v2_d [ENTRIES];
   logic [TAGW-1:0]    t1_q [ENTRIES];
   logic [TAGW-1:0]    t1_d [ENTRIES];
   logic [TAGW-1:0]    t2_q [ENTRIES];
   logic [TAGW-1:0]    t2_d [ENTRIES];
   logic [TAGW-1:0]    sdes_q [ENTRIES];
   logic [TAGW-1:0]    sdes_d [ENTRIES];
   logic [CNTW-1:0]    count_q, count_d;

   state_t             state_q;
   logic               fla_q;
   logic [XLEN-1:0]    data1_q, data2_q;
   logic [TAGW-1:0]    des_q;
   logic [6:0]         fun7o_q;

   logic [ENTRIES-1:0] wake1_s, wake2_s, elig_s;
   logic [IDXW-1:0]    disp_idx_s, free_idx_s;
   logic               disp_ok_s, issue_ready_s, iss_ok_s, cap1_s, cap2_s;
   logic [XLEN-1:0]    disp_v1_s, disp_v2_s;

   // Wakeup match, eligibility, and lowest-index selection for dispatch and issue.
   always_comb begin
      disp_idx_s = {IDXW{1'b0}};
      free_idx_s = {IDXW{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
         wake1_s[i] = valid_q[i] && !r1_q[i] && rs.cdb_valid && (t1_q[i] == rs.cdb_tag);
         wake2_s[i] = valid_q[i] && !r2_q[i] && rs.cdb_valid && (t2_q[i] == rs.cdb_tag);
`ifdef RS_WAKE_BYPASS_EN
         elig_s[i]  = valid_q[i] && (r1_q[i] || wake1_s[i]) && (r2_q[i] || wake2_s[i]);
`else
         elig_s[i]  = valid_q[i] && r1_q[i] && r2_q[i];
`endif
      end
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         disp_idx_s = elig_s[i]   ? IDXW'(i) : disp_idx_s;
         free_idx_s = !valid_q[i] ? IDXW'(i) : free_idx_s;
      end
      disp_ok_s     = (state_q == IDLE) && (|elig_s);
      issue_ready_s = !(&valid_q);
      iss_ok_s      = rs.issue_valid && issue_ready_s;
      cap1_s        = rs.cdb_valid && (rs.cdb_tag == rs.issue_tag1);
      cap2_s        = rs.cdb_valid && (rs.cdb_tag == rs.issue_tag2);
`ifdef RS_WAKE_BYPASS_EN
      // A source still pending in the registered copy is being delivered on the CDB right now.
      disp_v1_s = r1_q[disp_idx_s] ? v1_q[disp_idx_s] : rs.cdb_data;
      disp_v2_s = r2_q[disp_idx_s] ? v2_q[disp_idx_s] : rs.cdb_data;
`else
      disp_v1_s = v1_q[disp_idx_s];
      disp_v2_s = v2_q[disp_idx_s];
`endif
   end

   // Slot next state: CDB wakeup, free on dispatch, then write of a newly issued op.
   always_comb begin
      valid_d = valid_q;
      r1_d    = r1_q;
      r2_d    = r2_q;
      fun7_d  = fun7_q;
      v1_d    = v1_q;
      v2_d    = v2_q;
      t1_d    = t1_q;
      t2_d    = t2_q;
      sdes_d  = sdes_q;
      count_d = {CNTW{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
         if (wake1_s[i]) begin
            v1_d[i] = rs.cdb_data;
            r1_d[i] = 1'b1;
         end else begin
            v1_d[i] = v1_q[i];
         end
         if (wake2_s[i]) begin
            v2_d[i] = rs.cdb_data;
            r2_d[i] = 1'b1;
         end else begin
            v2_d[i] = v2_q[i];
         end
         if (disp_ok_s && (disp_idx_s == IDXW'(i))) begin
            valid_d[i] = 1'b0;
         end else begin
            valid_d[i] = valid_q[i];
         end
         if (iss_ok_s && (free_idx_s == IDXW'(i))) begin
            valid_d[i] = 1'b1;
            fun7_d[i]  = rs.issue_fun7;
            sdes_d[i]  = rs.issue_des;
            t1_d[i]    = rs.issue_tag1;
            t2_d[i]    = rs.issue_tag2;
            r1_d[i]    = rs.issue_rdy1 || cap1_s;
            r2_d[i]    = rs.issue_rdy2 || cap2_s;
            v1_d[i]    = (!rs.issue_rdy1 && cap1_s) ? rs.cdb_data : rs.issue_val1;
            v2_d[i]    = (!rs.issue_rdy2 && cap2_s) ? rs.cdb_data : rs.issue_val2;
         end else begin
            fun7_d[i]  = fun7_q[i];
         end
         count_d = count_d + (valid_d[i] ? CNTW'(1) : CNTW'(0));
      end
   end

   // Slot storage and occupancy count.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         valid_q <= {ENTRIES{1'b0}};
         r1_q    <= {ENTRIES{1'b0}};
         r2_q    <= {ENTRIES{1'b0}};
         count_q <= {CNTW{1'b0}};
         for (int i = 0; i < ENTRIES; i++) begin
            fun7_q[i] <= 7'd0;
            v1_q[i]   <= {XLEN{1'b0}};
            v2_q[i]   <= {XLEN{1'b0}};
            t1_q[i]   <= {TAGW{1'b0}};
            t2_q[i]   <= {TAGW{1'b0}};
            sdes_q[i] <= {TAGW{1'b0}};
         end
      end else begin
         valid_q <= valid_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         count_q <= count_d;
         fun7_q  <= fun7_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         t1_q    <= t1_d;
         t2_q    <= t2_d;
         sdes_q  <= sdes_d;
      end
   end

   // Dispatch FSM: fire once from IDLE, then wait in BUSY for the adder to complete.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         fla_q   <= 1'b0;
         data1_q <= {XLEN{1'b0}};
         data2_q <= {XLEN{1'b0}};
         des_q   <= {TAGW{1'b0}};
         fun7o_q <= 7'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (disp_ok_s) begin
                  data1_q <= disp_v1_s;
                  data2_q <= disp_v2_s;
                  des_q   <= sdes_q[disp_idx_s];
                  fun7o_q <= fun7_q[disp_idx_s];
                  fla_q   <= 1'b1;
                  state_q <= BUSY;
               end else begin
                  fla_q   <= 1'b0;
               end
            end
            BUSY: begin
               fla_q <= 1'b0;
               if (rs.adder_done) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= BUSY;
               end
            end
            default: begin
               fla_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rs.issue_ready = issue_ready_s;
   assign rs.count       = count_q;
   assign rs.fla         = fla_q;
   assign rs.data1       = data1_q;
   assign rs.data2       = data2_q;
   assign rs.des         = des_q;
   assign rs.fun7        = fun7o_q;
endmodule

// File: tb/tb_add_rs_station.sv
// Directed table-driven bench for add_rs_station, plus a hand-written async-reset-in-BUSY sequence.
module tb_add_rs_station;
   typedef struct {
      logic        iv;
      logic [6:0]  f7;
      logic [31:0] v1, v2;
      logic        r1, r2;
      logic [2:0]  t1, t2, des;
      logic        cv;
      logic [2:0]  ctag;
      logic [31:0] cdata;
      logic        done;
      logic        efla;
      logic [31:0] ed1, ed2;
      logic [2:0]  edes;
      logic [6:0]  ef7;
      logic [1:0]  ecnt;
      logic        erdy;
   } vec_t;

   logic clk1 = 1'b0;
   logic rst  = 1'b1;
   int   total = 0;
   int   bad   = 0;
   vec_t tbl[$];

   add_rs_if #(.ENTRIES(3), .XLEN(32), .TAGW(3)) rs_if ();
   add_rs_station #(.ENTRIES(3), .XLEN(32), .TAGW(3)) dut (.clk1(clk1), .rst(rst), .rs(rs_if));

   always #5 clk1 = ~clk1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic row(input logic iv, input logic [6:0] f7, input logic [31:0] v1, input logic [31:0] v2,
                      input logic r1, input logic r2, input logic [2:0] t1, input logic [2:0] t2,
                      input logic [2:0] des, input logic cv, input logic [2:0] ctag,
                      input logic [31:0] cdata, input logic done, input logic efla,
                      input logic [31:0] ed1, input logic [31:0] ed2, input logic [2:0] edes,
                      input logic [6:0] ef7, input logic [1:0] ecnt, input logic erdy);
      vec_t v;
      v.iv = iv; v.f7 = f7; v.v1 = v1; v.v2 = v2; v.r1 = r1; v.r2 = r2; v.t1 = t1; v.t2 = t2;
      v.des = des; v.cv = cv; v.ctag = ctag; v.cdata = cdata; v.done = done; v.efla = efla;
      v.ed1 = ed1; v.ed2 = ed2; v.edes = edes; v.ef7 = ef7; v.ecnt = ecnt; v.erdy = erdy;
      tbl.push_back(v);
   endtask

   task automatic idle_inputs();
      rs_if.issue_valid = 1'b0; rs_if.issue_fun7 = 7'd0;
      rs_if.issue_val1 = 32'd0; rs_if.issue_val2 = 32'd0;
      rs_if.issue_rdy1 = 1'b0; rs_if.issue_rdy2 = 1'b0;
      rs_if.issue_tag1 = 3'd0; rs_if.issue_tag2 = 3'd0; rs_if.issue_des = 3'd0;
      rs_if.cdb_valid = 1'b0; rs_if.cdb_tag = 3'd0; rs_if.cdb_data = 32'd0;
      rs_if.adder_done = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic efla, input logic [31:0] ed1, input logic [31:0] ed2,
                          input logic [2:0] edes, input logic [6:0] ef7, input logic [1:0] ecnt,
                          input logic erdy);
      chk({tag, ".fla"},   {31'd0, rs_if.fla}, {31'd0, efla});
      chk({tag, ".data1"}, rs_if.data1, ed1);
      chk({tag, ".data2"}, rs_if.data2, ed2);
      chk({tag, ".des"},   {29'd0, rs_if.des}, {29'd0, edes});
      chk({tag, ".fun7"},  {25'd0, rs_if.fun7}, {25'd0, ef7});
      chk({tag, ".count"}, {30'd0, rs_if.count}, {30'd0, ecnt});
      chk({tag, ".ready"}, {31'd0, rs_if.issue_ready}, {31'd0, erdy});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] ADD, SUB;
      ADD = 7'b0000000;
      SUB = 7'b0100000;
      idle_inputs();
      repeat (2) @(posedge clk1);
      #1;
      chk_out("reset", 1'b0, 32'd0, 32'd0, 3'd0, 7'd0, 2'd0, 1'b1);
      rst = 1'b0;

      //   iv f7   v1      v2         r1   r2   t1   t2   des  cv   ctag cdata         dn   fla  d1      d2          des  f7   cnt  rdy
      row(1'b1, ADD, 32'd5, 32'd7, 1'b1, 1'b1, 3'd0, 3'd0, 3'd2, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, ADD, 2'd1, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'd5, 32'd7, 3'd2, ADD, 2'd0, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd5, 32'd7, 3'd2, ADD, 2'd0, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd7, 3'd2, ADD, 2'd0, 1'b1);
      // sub waiting on tag 4, woken by the CDB
      row(1'b1, SUB, 32'd0, 32'd3, 1'b0, 1'b1, 3'd4, 3'd0, 3'd5, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd5, 32'd7, 3'd2, ADD, 2'd1, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd5, 32'd7, 3'd2, ADD, 2'd1, 1'b1);
`ifdef RS_WAKE_BYPASS_EN
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd4, 32'd10, 1'b0, 1'b1, 32'd10, 32'd3, 3'd5, SUB, 2'd0, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd10, 32'd3, 3'd5, SUB, 2'd0, 1'b1);
`else
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd4, 32'd10, 1'b0, 1'b0, 32'd5, 32'd7, 3'd2, ADD, 2'd1, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'd10, 32'd3, 3'd5, SUB, 2'd0, 1'b1);
`endif
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'd10, 32'd3, 3'd5, SUB, 2'd0, 1'b1);
      // fill the station while the adder is busy
      row(1'b1, ADD, 32'd1, 32'd2, 1'b1, 1'b1, 3'd0, 3'd0, 3'd1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd10, 32'd3, 3'd5, SUB, 2'd1, 1'b1);
      row(1'b1, ADD, 32'd3, 32'd4, 1'b1, 1'b1, 3'd0, 3'd0, 3'd3, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'd1, 32'd2, 3'd1, ADD, 2'd1, 1'b1);
      row(1'b1, ADD, 32'd6, 32'd7, 1'b1, 1'b1, 3'd0, 3'd0, 3'd4, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd1, 32'd2, 3'd1, ADD, 2'd2, 1'b1);
      row(1'b1, ADD, 32'd8, 32'd9, 1'b1, 1'b1, 3'd0, 3'd0, 3'd6, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd1, 32'd2, 3'd1, ADD, 2'd3, 1'b0);
      row(1'b1, ADD, 32'hAA, 32'hBB, 1'b1, 1'b1, 3'd0, 3'd0, 3'd7, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd1, 32'd2, 3'd1, ADD, 2'd3, 1'b0);
      row(1'b1, ADD, 32'hAA, 32'hBB, 1'b1, 1'b1, 3'd0, 3'd0, 3'd7, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'd1, 32'd2, 3'd1, ADD, 2'd3, 1'b0);
      // full station dispatches slot 0; the concurrent issue is refused
      row(1'b1, ADD, 32'hAA, 32'hBB, 1'b1, 1'b1, 3'd0, 3'd0, 3'd7, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'd6, 32'd7, 3'd4, ADD, 2'd2, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'd6, 32'd7, 3'd4, ADD, 2'd2, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'd3, 32'd4, 3'd3, ADD, 2'd1, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'd3, 32'd4, 3'd3, ADD, 2'd1, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'd8, 32'd9, 3'd6, ADD, 2'd0, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'd8, 32'd9, 3'd6, ADD, 2'd0, 1'b1);
      // capture at issue from a same-cycle CDB broadcast
      row(1'b1, ADD, 32'h11, 32'd0, 1'b1, 1'b0, 3'd0, 3'd6, 3'd0, 1'b1, 3'd6, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd8, 32'd9, 3'd6, ADD, 2'd1, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'h11, 32'hFFFFFFFF, 3'd0, ADD, 2'd0, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'h11, 32'hFFFFFFFF, 3'd0, ADD, 2'd0, 1'b1);
      row(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'h11, 32'hFFFFFFFF, 3'd0, ADD, 2'd0, 1'b1);
      // get into BUSY with two slots occupied
      row(1'b1, ADD, 32'h21, 32'h22, 1'b1, 1'b1, 3'd0, 3'd0, 3'd2, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'h11, 32'hFFFFFFFF, 3'd0, ADD, 2'd1, 1'b1);
      row(1'b1, ADD, 32'h31, 32'h32, 1'b1, 1'b1, 3'd0, 3'd0, 3'd3, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'h21, 32'h22, 3'd2, ADD, 2'd1, 1'b1);
      row(1'b1, ADD, 32'h41, 32'h42, 1'b1, 1'b1, 3'd0, 3'd0, 3'd4, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'h21, 32'h22, 3'd2, ADD, 2'd2, 1'b1);

      for (int i = 0; i < tbl.size(); i++) begin
         rs_if.issue_valid = tbl[i].iv;  rs_if.issue_fun7 = tbl[i].f7;
         rs_if.issue_val1  = tbl[i].v1;  rs_if.issue_val2 = tbl[i].v2;
         rs_if.issue_rdy1  = tbl[i].r1;  rs_if.issue_rdy2 = tbl[i].r2;
         rs_if.issue_tag1  = tbl[i].t1;  rs_if.issue_tag2 = tbl[i].t2;
         rs_if.issue_des   = tbl[i].des; rs_if.cdb_valid  = tbl[i].cv;
         rs_if.cdb_tag     = tbl[i].ctag; rs_if.cdb_data  = tbl[i].cdata;
         rs_if.adder_done  = tbl[i].done;
         @(posedge clk1);
         #1;
         chk_out($sformatf("row%0d", i), tbl[i].efla, tbl[i].ed1, tbl[i].ed2, tbl[i].edes,
                 tbl[i].ef7, tbl[i].ecnt, tbl[i].erdy);
      end

      // asynchronous reset in BUSY with two valid slots
      idle_inputs();
      #1 rst = 1'b1;
      #1;
      chk_out("async_rst", 1'b0, 32'd0, 32'd0, 3'd0, 7'd0, 2'd0, 1'b1);
      #1 rst = 1'b0;
      rs_if.adder_done = 1'b1;
      @(posedge clk1);
      #1;
      chk_out("post_rst_done", 1'b0, 32'd0, 32'd0, 3'd0, 7'd0, 2'd0, 1'b1);
      rs_if.adder_done = 1'b0;
      @(posedge clk1);
      #1;
      chk_out("post_rst_idle", 1'b0, 32'd0, 32'd0, 3'd0, 7'd0, 2'd0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
